// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: WIDTH-bit operands processed LANE bits per clock, LSB lane first.
// Optional zero-result flag port out_zero is enabled by defining LOGICU_ZERO_FLAG_EN.
module seq_logic_unit #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef LOGICU_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int N  = WIDTH / LANE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    lane;
  logic [WIDTH-1:0] res_q;
  logic [LANE-1:0]  a_sl;
  logic [LANE-1:0]  b_sl;
  logic [LANE-1:0]  r_sl;

  function automatic logic [LANE-1:0] logic_op(input logic [2:0] o,
                                               input logic [LANE-1:0] x,
                                               input logic [LANE-1:0] y);
    logic [LANE-1:0] r;
    case (o)
      3'b000:  r = ~x;
      3'b001:  r = x & y;
      3'b010:  r = x | y;
      3'b011:  r = x ^ y;
      3'b100:  r = ~(x & y);
      3'b101:  r = ~(x | y);
      3'b110:  r = ~(x ^ y);
      default: r = x;
    endcase
    return r;
  endfunction

  // Slice of the captured operands selected by the lane counter
  always_comb begin
    a_sl = a_q[int'(lane) * LANE +: LANE];
    b_sl = b_q[int'(lane) * LANE +: LANE];
    r_sl = logic_op(op_q, a_sl, b_sl);
  end

`ifdef LOGICU_ZERO_FLAG_EN
  logic zflag;
  assign out_zero = zflag & out_valid;
`endif

  assign out_data = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lane      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      res_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef LOGICU_ZERO_FLAG_EN
      zflag     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            lane     <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
`ifdef LOGICU_ZERO_FLAG_EN
            zflag    <= 1'b1;
`endif
          end
        end
        BUSY: begin
          res_q[int'(lane) * LANE +: LANE] <= r_sl;
`ifdef LOGICU_ZERO_FLAG_EN
          zflag <= zflag & (r_sl == '0);
`endif
          if (lane == LAST_LANE) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            lane <= lane + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed bench for seq_logic_unit: a LANE=4 instance and a LANE=16 instance (out_zero when LOGICU_ZERO_FLAG_EN).
module tb_seq_logic_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [2:0]  op2 = '0;
  logic [15:0] a2 = '0;
  logic [15:0] b2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b0;
  logic [15:0] out_data2;
`ifdef LOGICU_ZERO_FLAG_EN
  logic        out_zero;
  logic        out_zero2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_logic_unit #(.WIDTH(16), .LANE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
`ifdef LOGICU_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  seq_logic_unit #(.WIDTH(16), .LANE(16)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op2), .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2)
`ifdef LOGICU_ZERO_FLAG_EN
    , .out_zero(out_zero2)
`endif
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one op, scramble inputs during BUSY, return cycles to out_valid (99 on timeout)
  task automatic start_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                          output int lat);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'b000; a = '0; b = '0;
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = 99;
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{3'b001, 16'hF0F0, 16'hFF00, 16'hF000};
    vecs[1] = '{3'b000, 16'h1234, 16'h0000, 16'hEDCB};
    vecs[2] = '{3'b011, 16'hAAAA, 16'h0FF0, 16'hA55A};
    vecs[3] = '{3'b101, 16'h00FF, 16'h0F00, 16'hF000};
    vecs[4] = '{3'b111, 16'hBEEF, 16'h1111, 16'hBEEF};
    vecs[5] = '{3'b001, 16'hFFFF, 16'h00FF, 16'h00FF};
    vecs[6] = '{3'b100, 16'hFF0F, 16'h0FFF, 16'hF0F0};

    #12;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i), lat, 32'd4);
      chk($sformatf("vec%0d_data", i), {16'd0, out_data}, {16'd0, vecs[i].exp});
      consume($sformatf("vec%0d", i));
    end

    // Backpressure with an ignored in_valid pulse during the stall
    start_op(3'b010, 16'h0001, 16'h8000, lat);
    chk("bp_latency", lat, 32'd4);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin op = 3'b000; a = 16'h0F0F; b = 16'h0; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("bp_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_data_c%0d", c), {16'd0, out_data}, 32'h8001);
      chk($sformatf("bp_in_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    consume("bp");
    @(posedge clk); #1;
    chk("bp_not_queued_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_not_queued_ready", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset with lane counter at 2
    @(negedge clk);
    op = 3'b111; a = 16'hBEEF; b = 16'h0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_data", {16'd0, out_data}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(3'b110, 16'h5555, 16'h5555, lat);
    chk("post_rst_latency", lat, 32'd4);
    chk("post_rst_data", {16'd0, out_data}, 32'hFFFF);
    consume("post_rst");

    // Full-width lane: result valid one cycle after accept
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      op2 = 3'b011; a2 = 16'h1234; b2 = (k == 0) ? 16'h1234 : 16'h1235; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0; a2 = 16'hFFFF; b2 = 16'h0;
      chk($sformatf("wide%0d_not_early", k), {31'd0, out_valid2}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("wide%0d_valid", k), {31'd0, out_valid2}, 32'd1);
      chk($sformatf("wide%0d_data", k), {16'd0, out_data2}, (k == 0) ? 32'h0 : 32'h1);
`ifdef LOGICU_ZERO_FLAG_EN
      chk($sformatf("wide%0d_zero", k), {31'd0, out_zero2}, (k == 0) ? 32'd1 : 32'd0);
`endif
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
      chk($sformatf("wide%0d_drop", k), {31'd0, out_valid2}, 32'd0);
`ifdef LOGICU_ZERO_FLAG_EN
      chk($sformatf("wide%0d_zero_idle", k), {31'd0, out_zero2}, 32'd0);
`endif
      chk($sformatf("wide%0d_in_ready", k), {31'd0, in_ready2}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_logic_unit.md
# seq_logic_unit

Parametrised, multi-cycle bitwise logic unit, the next generation after the fixed 16-bit Not/And/Or gate arrays. It processes WIDTH-bit operands one LANE-bit slice per clock. It supports eight bitwise operations selected at run time and uses a valid/ready handshake on both sides. It sits between the Hack CPU datapath and wide operand sources, where a full-width gate array costs too much area.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of LANE
- LANE, 4, bits processed per cycle; 1 ≤ LANE ≤ WIDTH; N = WIDTH/LANE lane steps
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands and op presented
- in_ready  output  1  unit can accept (high only in IDLE)
- op  input  3  operation select, sampled at accept
- a  input  WIDTH  operand A, sampled at accept
- b  input  WIDTH  operand B, sampled at accept (ignored for NOT/PASS)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_data  output  WIDTH  result; defined only while out_valid=1
- out_zero  output  1  result == 0 (present only with LOGICU_ZERO_FLAG_EN)

## Operation
- Op encoding: 000 NOT a, 001 a AND b, 010 a OR b, 011 a XOR b, 100 NAND, 101 NOR, 110 XNOR, 111 PASS a.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, the unit captures a, b and op into internal registers, clears the lane counter to 0 and goes to BUSY.
- BUSY: each cycle computes slice [lane*LANE +: LANE] from the captured operands and writes it into the result register. Lanes are processed LSB first, and the counter increments each cycle. After lane N-1 is written, the unit goes to DONE.
- DONE: out_valid=1, and out_data holds the complete result stable. On out_ready=1 the unit goes to IDLE. out_data keeps its value until the next accept.
- Operand or op changes after accept have no effect on the operation in flight.
- in_ready=0 in BUSY and DONE. in_valid asserted then is ignored and not queued.
- Lane counter width is clog2(N), minimum 1 bit. It wraps to 0 only via accept; it is never compared past N-1.
- Asynchronous reset, at any time including mid-BUSY or DONE:
  - state=IDLE, lane counter=0
  - out_valid=0, out_data=0, in_ready=1
  - the internal a/b/op registers are cleared to 0
  - out_zero=0 when LOGICU_ZERO_FLAG_EN is defined
  - the partial result is discarded.

## Timing
- Accept at edge k. Lanes are written at edges k+1 … k+N. out_valid rises after edge k+N, giving N cycles from accept to out_valid.
- out_valid&&out_ready at edge m: out_valid=0 and in_ready=1 after edge m. The next accept is possible at edge m+1 at the earliest.
- Maximum throughput is one operation per N+2 cycles.
- LANE=WIDTH: N=1, and the result is valid one cycle after accept.
- out_valid stays high indefinitely while out_ready=0, with out_data unchanged.
- out_ready asserted while not in DONE has no effect.

## Configuration
- LOGICU_ZERO_FLAG_EN defined:
  - the out_zero port exists.
  - a sticky flag is set to 1 at accept and ANDed with (slice==0) at each lane write.
  - out_zero equals this flag while out_valid=1 and is 0 otherwise.
  - reset value is 0.
- LOGICU_ZERO_FLAG_EN undefined: no out_zero port and no flag register; all other behaviour is identical.

## Test plan
- WIDTH=16, LANE=4, op=001, a=0xF0F0, b=0xFF00, out_ready=1 -> out_valid rises 4 cycles after accept with out_data=0xF000 and holds for 1 cycle; in_ready returns the next cycle.
- op=000, a=0x1234 -> 0xEDCB. op=011, a=0xAAAA, b=0x0FF0 -> 0xA55A. op=101, a=0x00FF, b=0x0F00 -> 0xF000. op=111, a=0xBEEF -> 0xBEEF.
- Backpressure: complete op=010 with a=0x0001 and b=0x8000, then hold out_ready=0 for 5 cycles. Required: out_valid=1 and out_data=0x8001 throughout, in_ready=0, and an in_valid pulse during the stall is ignored.
- Operand change: accept op=001, a=0xFFFF, b=0x00FF, then drive a=0 and b=0 during BUSY -> result 0x00FF.
- Reset mid-op: assert rst_n=0 in BUSY lane 2 -> immediately out_valid=0, out_data=0, in_ready=1. After release, a fresh op=110 with a=b=0x5555 gives 0xFFFF at latency 4.
- WIDTH=16, LANE=16, with LOGICU_ZERO_FLAG_EN defined, op=011, a=b=0x1234 -> out_valid 1 cycle after accept, out_data=0x0000, out_zero=1. Next op=011 with a=0x1234, b=0x1235 -> out_data=0x0001, out_zero=0.
